// File: rtl/instruction_decoder.sv
// RV32I decode stage: pops {pc, inst} from the instruction queue, decodes the fields and
// holds up to two decoded entries so the queue pop never depends on dispatch readiness.
module instruction_decoder #(
  parameter int ADDR_WIDTH = 17,
  parameter int INST_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rdy,
  input  logic                             flush,
  input  logic                             iq_valid,
  input  logic [ADDR_WIDTH+INST_WIDTH-1:0] iq_entry,
  output logic                             iq_pop,
  output logic                             dec_valid,
  input  logic                             dec_ready,
  output logic [ADDR_WIDTH-1:0]            dec_pc,
  output logic [4:0]                       dec_opcode,
  output logic [2:0]                       dec_funct3,
  output logic                             dec_funct7b,
  output logic [4:0]                       dec_rd,
  output logic [4:0]                       dec_rs1,
  output logic [4:0]                       dec_rs2,
  output logic [31:0]                      dec_imm,
  output logic                             dec_use_rs1,
  output logic                             dec_use_rs2,
  output logic                             dec_write_rd,
  output logic                             dec_illegal
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [4:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7b;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [31:0]           imm;
    logic                  use_rs1;
    logic                  use_rs2;
    logic                  write_rd;
    logic                  illegal;
  } slot_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  logic [INST_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] pc;
  logic [31:0]           imm_i, imm_s, imm_b, imm_u, imm_j;

  assign inst  = iq_entry[INST_WIDTH-1:0];
  assign pc    = iq_entry[ADDR_WIDTH+INST_WIDTH-1:INST_WIDTH];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  slot_t       dec_n;
  logic        legal, use_rd, use_rs1, use_rs2, funct7b;
  logic [2:0]  f3;
  logic [31:0] imm;

  always_comb begin
    legal   = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    funct7b = 1'b0;
    imm     = '0;
    f3      = inst[14:12];
    case (inst[6:2])
      OP_LUI, OP_AUIPC: begin
        f3     = 3'b000;
        imm    = imm_u;
        use_rd = 1'b1;
      end
      OP_JAL: begin
        f3     = 3'b000;
        imm    = imm_j;
        use_rd = 1'b1;
      end
      OP_JALR: begin
        legal   = (inst[14:12] == 3'b000);
        imm     = imm_i;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_LOAD: begin
        legal   = !(inst[14:12] == 3'b011 || inst[14:12] == 3'b110 || inst[14:12] == 3'b111);
        imm     = imm_i;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_OPIMM: begin
        // Shift-immediates carry a 5-bit shamt, not a sign-extended immediate
        if (inst[13:12] == 2'b01) imm = {27'b0, inst[24:20]};
        else                      imm = imm_i;
        funct7b = (inst[14:12] == 3'b101) ? inst[30] : 1'b0;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_BRANCH: begin
        legal   = (inst[14:13] != 2'b01);
        imm     = imm_b;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_STORE: begin
        legal   = (inst[14:12] < 3'b011);
        imm     = imm_s;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_OP: begin
        funct7b = inst[30];
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (inst[1:0] != 2'b11) legal = 1'b0;

    dec_n        = '0;
    dec_n.pc     = pc;
    dec_n.opcode = inst[6:2];
    dec_n.funct3 = f3;
    if (legal) begin
      dec_n.funct7b  = funct7b;
      dec_n.imm      = imm;
      dec_n.use_rs1  = use_rs1;
      dec_n.use_rs2  = use_rs2;
      dec_n.rd       = use_rd  ? inst[11:7]  : 5'd0;
      dec_n.rs1      = use_rs1 ? inst[19:15] : 5'd0;
      dec_n.rs2      = use_rs2 ? inst[24:20] : 5'd0;
      dec_n.write_rd = use_rd && (inst[11:7] != 5'd0);
    end else begin
      dec_n.illegal = 1'b1;
    end
  end

  slot_t      head, tail;
  logic [1:0] count, wr_idx;
  logic       push, pop_out;

  assign iq_pop    = rdy && !rst && !flush && (count < 2'd2);
  assign push      = iq_valid && iq_pop;
  assign dec_valid = (count != 2'd0);
  assign pop_out   = dec_valid && dec_ready && rdy;
  assign wr_idx    = count - {1'b0, pop_out};

  // The push write follows the shift so a push+pop at count=1 lands the new entry in head
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else if (rdy) begin
      if (flush) begin
        count <= 2'd0;
      end else begin
        if (pop_out) head <= tail;
        if (push) begin
          if (wr_idx == 2'd0) head <= dec_n;
          else                tail <= dec_n;
        end
        count <= count + {1'b0, push} - {1'b0, pop_out};
      end
    end
  end

  assign dec_pc       = head.pc;
  assign dec_opcode   = head.opcode;
  assign dec_funct3   = head.funct3;
  assign dec_funct7b  = head.funct7b;
  assign dec_rd       = head.rd;
  assign dec_rs1      = head.rs1;
  assign dec_rs2      = head.rs2;
  assign dec_imm      = head.imm;
  assign dec_use_rs1  = head.use_rs1;
  assign dec_use_rs2  = head.use_rs2;
  assign dec_write_rd = head.write_rd;
  assign dec_illegal  = head.illegal;

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: a vector table of hand-decoded instructions feeds a scoreboard
// queue, plus directed sequences for backpressure, flush, freeze and reset.
module tb_instruction_decoder;
  localparam int AW = 17;
  localparam int IW = 32;
  localparam int NV = 13;

  logic           clk = 1'b0;
  logic           rst, rdy, flush, iq_valid, dec_ready;
  logic [AW+IW-1:0] iq_entry;
  logic           iq_pop, dec_valid, dec_funct7b;
  logic [AW-1:0]  dec_pc;
  logic [4:0]     dec_opcode, dec_rd, dec_rs1, dec_rs2;
  logic [2:0]     dec_funct3;
  logic [31:0]    dec_imm;
  logic           dec_use_rs1, dec_use_rs2, dec_write_rd, dec_illegal;

  always #5 clk = ~clk;

  instruction_decoder #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .iq_valid(iq_valid), .iq_entry(iq_entry), .iq_pop(iq_pop),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
    .dec_opcode(dec_opcode), .dec_funct3(dec_funct3), .dec_funct7b(dec_funct7b),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_imm(dec_imm),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_write_rd(dec_write_rd), .dec_illegal(dec_illegal)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [4:0]    opcode;
    logic [2:0]    funct3;
    logic          funct7b;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [31:0]   imm;
    logic          use_rs1;
    logic          use_rs2;
    logic          write_rd;
    logic          illegal;
  } dec_rec_t;

  typedef struct packed {
    logic [31:0] inst;
    dec_rec_t    exp;
  } vec_t;

  vec_t     vec [NV];
  dec_rec_t exp_q[$];
  int checks = 0, failures = 0, pushes = 0, disp_count = 0, feed_limit = 0;

  function automatic vec_t mk(input logic [AW-1:0] pc, input logic [31:0] inst,
                              input logic [4:0] op, input logic [2:0] f3, input logic f7,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic u1, input logic u2,
                              input logic w, input logic ill);
    vec_t v;
    v.inst = inst;
    v.exp  = '{pc, op, f3, f7, rd, rs1, rs2, imm, u1, u2, w, ill};
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Queue head is vec[pushes % NV] until it is popped; valid only up to feed_limit pushes
  task automatic set_entry();
    iq_valid = (pushes < feed_limit);
    iq_entry = {vec[pushes % NV].exp.pc, vec[pushes % NV].inst};
  endtask

  task automatic apply_stimulus(input logic r, input logic f, input logic dr, input int more);
    rdy        = r;
    flush      = f;
    dec_ready  = dr;
    feed_limit = pushes + more;
    set_entry();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    set_entry();
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic run_until_drained(input string name, input int bound);
    int n = 0;
    while (n < bound && !(pushes >= feed_limit && exp_q.size() == 0 && !dec_valid)) begin
      tick();
      n++;
    end
    check_output({name, "_drained"}, 32'(n < bound), 32'd1);
  endtask

  // Scoreboard: dispatches are compared against the oldest expected entry, pops enqueue the next
  always @(negedge clk) begin
    dec_rec_t got, e;
    if (rst || (rdy && flush)) begin
      exp_q.delete();
    end else begin
      if (dec_valid && dec_ready && rdy) begin
        disp_count++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL dispatch_unexpected: got pc 0x%0h, expected no dispatch", dec_pc);
        end else begin
          e   = exp_q.pop_front();
          got = '{dec_pc, dec_opcode, dec_funct3, dec_funct7b, dec_rd, dec_rs1, dec_rs2,
                  dec_imm, dec_use_rs1, dec_use_rs2, dec_write_rd, dec_illegal};
          if (e.illegal) got.funct3 = e.funct3;
          if (got !== e) begin
            failures++;
            $display("[TB] FAIL dispatch_pc_%0h: got %h, expected %h", e.pc, got, e);
          end
        end
      end
      if (iq_valid && iq_pop) begin
        exp_q.push_back(vec[pushes % NV].exp);
        pushes++;
      end
    end
  end

  initial begin
    int base, s_push, s_disp, n;
    logic [AW-1:0] head_pc;

    vec[0]  = mk(17'h00010, 32'h123452B7, 5'h0D, 3'd0, 1'b0, 5'd5,  5'd0, 5'd0, 32'h12345000, 1'b0, 1'b0, 1'b1, 1'b0);
    vec[1]  = mk(17'h00014, 32'hFFF00093, 5'h04, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    vec[2]  = mk(17'h00100, 32'hFE208CE3, 5'h18, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'hFFFFFFF8, 1'b1, 1'b1, 1'b0, 1'b0);
    vec[3]  = mk(17'h00104, 32'h00000000, 5'h00, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1);
    vec[4]  = mk(17'h00108, 32'h402081B3, 5'h0C, 3'd0, 1'b1, 5'd3,  5'd1, 5'd2, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0);
    vec[5]  = mk(17'h0010C, 32'h40335293, 5'h04, 3'd5, 1'b1, 5'd5,  5'd6, 5'd0, 32'h00000003, 1'b1, 1'b0, 1'b1, 1'b0);
    vec[6]  = mk(17'h00110, 32'h00712623, 5'h08, 3'd2, 1'b0, 5'd0,  5'd2, 5'd7, 32'h0000000C, 1'b1, 1'b1, 1'b0, 1'b0);
    vec[7]  = mk(17'h00114, 32'h010000EF, 5'h1B, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h00000010, 1'b0, 1'b0, 1'b1, 1'b0);
    vec[8]  = mk(17'h00118, 32'h0000B083, 5'h00, 3'd3, 1'b0, 5'd0,  5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1);
    vec[9]  = mk(17'h1FFFC, 32'h00000013, 5'h04, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    vec[10] = mk(17'h00120, 32'hFFFFF517, 5'h05, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'hFFFFF000, 1'b0, 1'b0, 1'b1, 1'b0);
    vec[11] = mk(17'h00124, 32'h123452B6, 5'h0D, 3'd2, 1'b0, 5'd0,  5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1);
    vec[12] = mk(17'h00128, 32'h004100E7, 5'h19, 3'd0, 1'b0, 5'd1,  5'd2, 5'd0, 32'h00000004, 1'b1, 1'b0, 1'b1, 1'b0);

    rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 0);
    tick();
    tick();
    settle();
    check_output("reset_iq_pop", 32'(iq_pop), 32'd0);
    check_output("reset_dec_valid", 32'(dec_valid), 32'd0);
    rst = 1'b0;
    tick();
    settle();
    check_output("reset_pc", 32'(dec_pc), 32'd0);
    check_output("reset_imm", dec_imm, 32'd0);
    check_output("reset_opcode", 32'(dec_opcode), 32'd0);
    check_output("reset_flags", {28'd0, dec_use_rs1, dec_use_rs2, dec_write_rd, dec_illegal}, 32'd0);
    check_output("idle_iq_pop", 32'(iq_pop), 32'd1);

    $display("[TB] single entry latency");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1);
    tick();
    settle();
    check_output("latency_valid", 32'(dec_valid), 32'd1);
    check_output("latency_pc", 32'(dec_pc), 32'h10);
    check_output("latency_rd", 32'(dec_rd), 32'd5);
    tick();
    settle();
    check_output("after_dispatch_valid", 32'(dec_valid), 32'd0);

    $display("[TB] table stream");
    apply_stimulus(1'b1, 1'b0, 1'b1, NV - 1);
    run_until_drained("table", 60);
    check_output("table_dispatches", 32'(disp_count), 32'(NV));

    $display("[TB] backpressure");
    base = pushes;
    apply_stimulus(1'b1, 1'b0, 1'b0, 6);
    for (int i = 0; i < 6; i++) tick();
    settle();
    check_output("bp_pops", 32'(pushes - base), 32'd2);
    check_output("bp_iq_pop", 32'(iq_pop), 32'd0);
    dec_ready = 1'b1;
    #0;
    check_output("bp_full_ready_iq_pop", 32'(iq_pop), 32'd0);
    run_until_drained("bp", 40);
    check_output("bp_total_pops", 32'(pushes - base), 32'd6);

    $display("[TB] flush when full");
    apply_stimulus(1'b1, 1'b0, 1'b0, 2);
    n = 0;
    while (pushes < feed_limit && n < 10) begin
      tick();
      n++;
    end
    check_output("flush_fill", 32'(n < 10), 32'd1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 3);
    settle();
    check_output("flush_full_valid", 32'(dec_valid), 32'd1);
    check_output("flush_iq_pop", 32'(iq_pop), 32'd0);
    tick();
    flush = 1'b0;
    settle();
    check_output("flush_after_valid", 32'(dec_valid), 32'd0);
    check_output("flush_after_iq_pop", 32'(iq_pop), 32'd1);
    dec_ready = 1'b1;
    run_until_drained("flush", 40);

    $display("[TB] rdy freeze");
    apply_stimulus(1'b1, 1'b0, 1'b1, 5);
    tick();
    tick();
    rdy = 1'b0;
    settle();
    s_push  = pushes;
    s_disp  = disp_count;
    head_pc = vec[(pushes - 1) % NV].exp.pc;
    for (int i = 0; i < 3; i++) begin
      check_output("freeze_iq_pop", 32'(iq_pop), 32'd0);
      check_output("freeze_valid", 32'(dec_valid), 32'd1);
      check_output("freeze_pc", 32'(dec_pc), 32'(head_pc));
      flush = (i == 1);
      tick();
      settle();
    end
    flush = 1'b0;
    check_output("freeze_no_pops", 32'(pushes), 32'(s_push));
    check_output("freeze_no_dispatch", 32'(disp_count), 32'(s_disp));
    check_output("freeze_end_valid", 32'(dec_valid), 32'd1);
    rdy = 1'b1;
    run_until_drained("freeze", 40);

    $display("[TB] reset mid-stream");
    apply_stimulus(1'b1, 1'b0, 1'b0, 2);
    tick();
    tick();
    settle();
    check_output("rst_mid_valid_before", 32'(dec_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check_output("rst_mid_valid", 32'(dec_valid), 32'd0);
    check_output("rst_mid_pc", 32'(dec_pc), 32'd0);
    check_output("rst_mid_imm", dec_imm, 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 3);
    run_until_drained("post_reset", 40);

    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
